key_input_ctrl: RTL

KEY_INPUT_CTRL -- requirements
Module: key_input_ctrl

---
 rtl/genius_pkg.sv | 36 +++
 rtl/key_input_ctrl_debounce_channel.sv | 58 +++++
 rtl/key_input_ctrl.sv | 84 ++++++++
 3 files changed

// File: rtl/genius_pkg.sv
// Shared key-code constants and helpers for the push-button front end.
// Codes follow the physical button order on the board.
package genius_pkg;

  localparam int NUM_KEYS   = 4;
  localparam int KEY_CODE_W = 2;

  typedef enum logic [KEY_CODE_W-1:0] {
    KEY_GREEN  = 2'd0,
    KEY_RED    = 2'd1,
    KEY_YELLOW = 2'd2,
    KEY_BLUE   = 2'd3
  } key_code_e;

  function automatic key_code_e lowest_key(
    input logic [NUM_KEYS-1:0] ev
  );
    key_code_e c;
    c = KEY_GREEN;
    priority case (1'b1)
      ev[0]:   c = KEY_GREEN;
      ev[1]:   c = KEY_RED;
      ev[2]:   c = KEY_YELLOW;
      ev[3]:   c = KEY_BLUE;
      default: c = KEY_GREEN;
    endcase
    return c;
  endfunction

  function automatic logic multi_hot(
    input logic [NUM_KEYS-1:0] v
  );
    return (v & (v - 1'b1)) != '0;
  endfunction

endpackage

// File: rtl/key_input_ctrl_debounce_channel.sv
// One button: 2-flop synchronizer, stability counter, debounced level
// and a one-cycle pulse on each accepted press.
import genius_pkg::*;

module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          synced;

  assign synced = ~sync_q[1];

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (synced != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = synced;
        rise_d  = synced;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_n_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/key_input_ctrl.sv
// Debounced button front end feeding a one-entry valid/ready key-code
// register with a sticky overrun flag for lost presses.
import genius_pkg::*;

module key_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET,
  input  logic [NUM_KEYS-1:0]   KEY,
  input  logic                  i_enable,
  input  logic                  i_key_ready,
  output logic                  o_key_valid,
  output logic [KEY_CODE_W-1:0] o_key_code,
  output logic [NUM_KEYS-1:0]   o_keys_level,
  input  logic                  i_clear_overrun,
  output logic                  o_overrun
);

  logic [NUM_KEYS-1:0]   level_w, rise_w, ev;
  logic                  valid_q, valid_d;
  logic [KEY_CODE_W-1:0] code_q, code_d;
  logic                  ovr_q, ovr_d;
  logic                  any_ev, xfer, lost;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk_i   (CLOCK_50),
      .rst_i   (RESET),
      .key_n_i (KEY[k]),
      .level_o (level_w[k]),
      .rise_o  (rise_w[k])
    );
  end

  assign ev     = rise_w & {NUM_KEYS{i_enable}};
  assign any_ev = |ev;
  assign xfer   = valid_q & i_key_ready;

  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    lost    = 1'b0;
    if (any_ev) begin
      // A transfer on this edge frees the slot for the new code.
      if (!valid_q || xfer) begin
        valid_d = 1'b1;
        code_d  = lowest_key(ev);
        lost    = multi_hot(ev);
      end else begin
        lost = 1'b1;
      end
    end else if (xfer) begin
      valid_d = 1'b0;
    end
    if (lost) begin
      ovr_d = 1'b1;
    end else if (i_clear_overrun) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      valid_q <= 1'b0;
      code_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      code_q  <= code_d;
      ovr_q   <= ovr_d;
    end
  end

  assign o_key_valid  = valid_q;
  assign o_key_code   = code_q;
  assign o_keys_level = level_w;
  assign o_overrun    = ovr_q;

endmodule
